serial_tx_piso: RTL and testbench
=================================

Name: serial_tx_piso

Overview:
- Parallel-in, serial-out transmitter: the sending end of the team's 4-bit parallel-load register path.
- On a load request, captures parallel word I and drives it onto a single-wire frame: start bit, data bits LSB-first, stop bit(s).
- A matching serial receiver rebuilds the word at the far end.
- Status outputs busy and done let an upstream controller pace loads.

Parameters:
WIDTH, 4, data word width in bits (minimum 2)
STOP_BITS, 1, number of stop-bit cycles (1 or 2)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  reset, synchronous, active-low (0 = reset on rising clk edge)
load  input  1  request to start a frame; sampled on rising clk edge
I  input  WIDTH  parallel data word; captured on the edge where load is accepted
sout  output  1  serial line; idles high
busy  output  1  high while a frame is in progress (START through last STOP cycle)
done  output  1  one-cycle pulse after the final stop bit of each frame

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset: rst=0 at a rising edge forces the following, regardless of load:
  - state IDLE, sout=1, busy=0, done=0
  - shift register = 0, bit counter = 0
- rst has priority over every other event, including mid-frame; a partial frame is abandoned and sout returns high on the next cycle.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - sout=1, busy=0.
  - load=1 at edge k: capture I into the shift register and enter START.
  - load=0: remain in IDLE.
- START: one cycle (edge k to k+1); sout=0, busy=1. Next state is DATA with counter=0.
- DATA:
  - WIDTH cycles; sout = shift register bit 0; the register shifts right by one each cycle.
  - Bit i of the captured I appears during cycle k+1+i.
  - Counter increments 0..WIDTH-1; at WIDTH-1 go to PARITY if enabled, else STOP.
- STOP: STOP_BITS cycles; sout=1, busy=1. After the last stop cycle return to IDLE.
- done: asserted for exactly the first IDLE cycle after STOP, with busy=0 in that same cycle.
- Frame length: 1+WIDTH+STOP_BITS cycles without parity (6 for defaults).
- load while busy=1: ignored; I is not re-sampled and the frame in progress is unaffected.
- load=1 in the done cycle: accepted (state is IDLE), giving back-to-back frames with no idle gap beyond that cycle.
- Changes to I after capture: no effect on the frame in progress.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP for one cycle.
  - sout = XOR of the captured WIDTH data bits (even parity).
  - Frame length becomes 2+WIDTH+STOP_BITS cycles.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
1. rst=0 for 2 edges, then rst=1, load=0 -> sout=1, busy=0, done=0 held in IDLE.
2. I=4'b1010, load=1 for one edge k -> sout over cycles k..k+5 = 0,0,1,0,1,1; busy=1 for those 6 cycles; done=1 only in cycle k+6.
3. During the frame of scenario 2, I=4'b1111 with load=1 at k+2 -> ignored; sout sequence identical to scenario 2, and exactly one done pulse.
4. I=4'b0011 loaded, rst=0 at edge k+3 (mid-DATA) -> next cycle sout=1, busy=0, done=0; no done pulse; a new load afterwards produces a clean frame 0,1,1,0,0,1.
5. load held high continuously, I=4'b1111 -> back-to-back frames 0,1,1,1,1,1 each 6 cycles, separated by one done/IDLE cycle (period 7 cycles).
6. SERIAL_TX_PARITY_EN defined: I=4'b1010 -> sout 0,0,1,0,1,0,1 (parity 0, frame 7 cycles); I=4'b0111 -> parity bit 1.

Source files
------------

// File: rtl/serial_tx_piso.sv
// serial_tx_piso: frame transmitter sending a start bit, WIDTH data bits LSB-first, then stop bit(s).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx_piso #(
    parameter int WIDTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] I,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
    logic par;
`endif
    logic [2:0]       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    // sout is registered, so each edge loads the value for the cycle that follows it
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            sout  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    state <= START;
                    sr    <= I;
                    sout  <= 1'b0;
                    busy  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    par   <= ^I;
`endif
                end
                START: begin
                    state <= DATA;
                    cnt   <= '0;
                    sout  <= sr[0];
                    sr    <= sr >> 1;
                end
                DATA: if (cnt == CW'(WIDTH - 1)) begin
                    cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                    state <= PARITY;
                    sout  <= par;
`else
                    state <= STOP;
                    sout  <= 1'b1;
`endif
                end else begin
                    cnt  <= cnt + 1'b1;
                    sout <= sr[0];
                    sr   <= sr >> 1;
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    state <= STOP;
                    sout  <= 1'b1;
                end
`endif
                STOP: if (cnt == CW'(STOP_BITS - 1)) begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    sout  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_piso.sv
// tb_serial_tx_piso: scoreboard bench; a frame model queues accepted words, a monitor checks every cycle.
module tb_serial_tx_piso;
    localparam int WIDTH = 4;
    localparam int STOP_BITS = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FLEN = 2 + WIDTH + STOP_BITS;
`else
    localparam int FLEN = 1 + WIDTH + STOP_BITS;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic sout, busy, done;
    int total = 0;
    int bad = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] cur = '0;
    int left = 0;
    int pos = 0;
    int rst_cnt = 0;
    int seen_rst = 0;

    serial_tx_piso #(.WIDTH(WIDTH), .STOP_BITS(STOP_BITS)) dut (
        .clk(clk), .rst(rst), .load(load), .I(din),
        .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int p);
        if (p == 0) return 1'b0;
        if (p <= WIDTH) return w[p-1];
`ifdef SERIAL_TX_PARITY_EN
        if (p == WIDTH + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, want);
        end
    endtask

    // frame-level model: a load is taken only when the previous cycle was not busy
    always @(posedge clk) begin
        if (!rst) begin
            rst_cnt++;
            left = 0;
            exp_q.delete();
        end else if (left == 0 && load) begin
            exp_q.push_back(din);
            left = FLEN;
        end else if (left > 0) begin
            left--;
        end
    end

    always @(negedge clk) begin
        if (rst_cnt != seen_rst) begin
            seen_rst = rst_cnt;
            pos = 0;
            check("reset_sout", int'(sout), 1);
            check("reset_busy", int'(busy), 0);
            check("reset_done", int'(done), 0);
        end else if (busy) begin
            if (pos == 0) begin
                check("frame_expected", exp_q.size() > 0 ? 1 : 0, 1);
                if (exp_q.size() > 0) cur = exp_q.pop_front();
            end
            check($sformatf("sout_bit%0d_w%0h", pos, cur), int'(sout), int'(frame_bit(cur, pos)));
            pos++;
        end else begin
            check("idle_sout", int'(sout), 1);
            if (pos != 0) begin
                check("frame_len", pos, FLEN);
                check("done_pulse", int'(done), 1);
            end else begin
                check("no_done", int'(done), 0);
            end
            pos = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(2);
        rst = 1'b1;
        cyc(3);
        din = 4'b1010; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(1);
        din = 4'b1111; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(8);
        din = 4'b0011; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(2);
        din = 4'b0011; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(8);
        din = 4'b1111; load = 1'b1;
        cyc(21);
        load = 1'b0;
        cyc(8);
        din = 4'b0111; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(8);
        for (int n = 0; n < 400; n++) begin
            load = ($urandom_range(0, 2) == 0);
            din = WIDTH'($urandom);
            rst = ($urandom_range(0, 59) != 0);
            cyc(1);
        end
        rst = 1'b1; load = 1'b0;
        cyc(FLEN + 3);
        check("queue_drained", exp_q.size(), 0);
        check("monitor_idle", pos, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
